// File: rtl/display_scan_controller.sv
// Samples address/data/keypad nibbles, splits each into units/tens with one shared
// subtract-10 unit, and scans the six BCD digits onto a single 7-segment decoder input.
module display_scan_controller #(
    parameter int unsigned REFRESH_DIV        = 50000,
    parameter int unsigned BLANK_LEADING_ZERO = 1,
    parameter int unsigned ENABLE_ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       update,
    input  logic [3:0] address_in,
    input  logic [3:0] data_in,
    input  logic [3:0] keypad_data_in,
    output logic       busy,
    output logic       done,
    output logic [5:0] digit_enable,
    output logic [3:0] digit_value,
    output logic       digit_blank
);

    localparam int unsigned PreW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(REFRESH_DIV - 1);
    localparam logic [5:0] EnDigit0 = (ENABLE_ACTIVE_LOW != 0) ? 6'b111110 : 6'b000001;

    typedef enum logic [2:0] {
        StIdle,
        StConvA,
        StConvD,
        StConvK,
        StCommit
    } state_e;

    state_e state_q, state_d;

    logic [3:0] samp_a_q, samp_d_q, samp_k_q;
    logic [3:0] stage_au_q, stage_at_q, stage_du_q, stage_dt_q, stage_ku_q, stage_kt_q;
    logic [3:0] disp_au_q, disp_at_q, disp_du_q, disp_dt_q, disp_ku_q, disp_kt_q;
    logic       busy_q, done_q;

    logic [3:0] conv_in, conv_units;
    logic       conv_tens;

    logic [PreW-1:0] presc_q;
    logic [2:0]      idx_q;
    logic            wrap;

    logic [3:0] sel_val;
    logic       sel_blank;
    logic [5:0] sel_onehot;
    logic [5:0] sel_enable;
    logic [5:0] en_q;
    logic [3:0] val_q;
    logic       blank_q;

    // ---------------------------------------------------------------- conversion FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_d == StCommit);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (update) state_d = StConvA;
            StConvA:  state_d = StConvD;
            StConvD:  state_d = StConvK;
            StConvK:  state_d = StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Shared subtract-10 unit; operand chosen by the current conversion state.
    always_comb begin
        case (state_q)
            StConvD: conv_in = samp_d_q;
            StConvK: conv_in = samp_k_q;
            default: conv_in = samp_a_q;
        endcase
        conv_tens  = (conv_in >= 4'd10);
        conv_units = conv_tens ? (conv_in - 4'd10) : conv_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_a_q   <= '0;
            samp_d_q   <= '0;
            samp_k_q   <= '0;
            stage_au_q <= '0;
            stage_at_q <= '0;
            stage_du_q <= '0;
            stage_dt_q <= '0;
            stage_ku_q <= '0;
            stage_kt_q <= '0;
            disp_au_q  <= '0;
            disp_at_q  <= '0;
            disp_du_q  <= '0;
            disp_dt_q  <= '0;
            disp_ku_q  <= '0;
            disp_kt_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (update) begin
                        samp_a_q <= address_in;
                        samp_d_q <= data_in;
                        samp_k_q <= keypad_data_in;
                    end
                end
                StConvA: begin
                    stage_au_q <= conv_units;
                    stage_at_q <= {3'b000, conv_tens};
                end
                StConvD: begin
                    stage_du_q <= conv_units;
                    stage_dt_q <= {3'b000, conv_tens};
                end
                StConvK: begin
                    stage_ku_q <= conv_units;
                    stage_kt_q <= {3'b000, conv_tens};
                end
                StCommit: begin
                    // All six digits change on the same edge so the scan never shows a mix.
                    disp_au_q <= stage_au_q;
                    disp_at_q <= stage_at_q;
                    disp_du_q <= stage_du_q;
                    disp_dt_q <= stage_dt_q;
                    disp_ku_q <= stage_ku_q;
                    disp_kt_q <= stage_kt_q;
                end
                default: ;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    // ---------------------------------------------------------------- digit scan
    assign wrap = (presc_q == PreMax);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= wrap ? '0 : presc_q + 1'b1;
            if (wrap) begin
                idx_q <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
            end
        end
    end

    always_comb begin
        case (idx_q)
            3'd0:    sel_val = disp_au_q;
            3'd1:    sel_val = disp_at_q;
            3'd2:    sel_val = disp_du_q;
            3'd3:    sel_val = disp_dt_q;
            3'd4:    sel_val = disp_ku_q;
            default: sel_val = disp_kt_q;
        endcase
        // Odd indices are tens digits; only those may be blanked.
        sel_blank  = (BLANK_LEADING_ZERO != 0) && idx_q[0] && (sel_val == 4'd0);
        sel_onehot = 6'b000001 << idx_q;
        sel_enable = (ENABLE_ACTIVE_LOW != 0) ? ~sel_onehot : sel_onehot;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q    <= EnDigit0;
            val_q   <= '0;
            blank_q <= 1'b0;
        end else begin
            en_q    <= sel_enable;
            val_q   <= sel_val;
            blank_q <= sel_blank;
        end
    end

    assign digit_enable = en_q;
    assign digit_value  = val_q;
    assign digit_blank  = blank_q;

    enable_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot((ENABLE_ACTIVE_LOW != 0) ? ~en_q : en_q));

    done_only_in_busy: assert property (@(posedge clk) disable iff (rst)
        done |-> busy);

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: vector table, directed corner sequences and
// randomized traffic checked cycle by cycle against a behavioural model.
module tb_display_scan_controller;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       update;
    logic [3:0] a_in, d_in, k_in;
    logic       busy, done, digit_blank;
    logic [5:0] digit_enable;
    logic [3:0] digit_value;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: edge count since reset, remaining conversion cycles, digits.
    int         m_k;
    int         m_cnt;
    logic [3:0] m_samp [3];
    logic [3:0] m_disp [6];
    int         m_out_idx;
    logic [3:0] m_out_val;
    logic       m_out_blank;

    typedef struct {
        logic [3:0]  a;
        logic [3:0]  d;
        logic [3:0]  k;
        logic [23:0] digits;  // nibble i is the digit at scan index i
        logic [5:0]  blanks;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    display_scan_controller #(
        .REFRESH_DIV       (DIV),
        .BLANK_LEADING_ZERO(1),
        .ENABLE_ACTIVE_LOW (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .update        (update),
        .address_in    (a_in),
        .data_in       (d_in),
        .keypad_data_in(k_in),
        .busy          (busy),
        .done          (done),
        .digit_enable  (digit_enable),
        .digit_value   (digit_value),
        .digit_blank   (digit_blank)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_k         = 0;
        m_cnt       = 0;
        m_out_idx   = 0;
        m_out_val   = 4'd0;
        m_out_blank = 1'b0;
        for (int i = 0; i < 3; i++) m_samp[i] = 4'd0;
        for (int i = 0; i < 6; i++) m_disp[i] = 4'd0;
    endtask

    task automatic check_model();
        logic [5:0] exp_en;
        exp_en = ~(6'b000001 << m_out_idx);
        check("busy", busy, m_cnt > 0);
        check("done", done, m_cnt == 1);
        check("enable", digit_enable, exp_en);
        check("value", digit_value, m_out_val);
        check("blank", digit_blank, m_out_blank);
    endtask

    // One clock edge: advance the model from pre-edge state, then compare 1 ns later.
    task automatic tick();
        @(posedge clk);
        m_out_idx   = (m_k / DIV) % 6;
        m_out_val   = m_disp[m_out_idx];
        m_out_blank = (m_out_idx % 2 == 1) && (m_out_val == 4'd0);
        m_k++;
        if (m_cnt == 1) begin
            for (int i = 0; i < 3; i++) begin
                m_disp[2*i]   = m_samp[i] % 10;
                m_disp[2*i+1] = m_samp[i] / 10;
            end
            m_cnt = 0;
        end else if (m_cnt > 0) begin
            m_cnt--;
        end else if (update) begin
            m_samp[0] = a_in;
            m_samp[1] = d_in;
            m_samp[2] = k_in;
            m_cnt     = 4;
        end
        #1;
        check_model();
    endtask

    // Assert reset mid-cycle, check the reset values while it is held, release at negedge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_enable", digit_enable, 6'b111110);
        check("rst_value", digit_value, 4'd0);
        check("rst_blank", digit_blank, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic request(input logic [3:0] a, input logic [3:0] d, input logic [3:0] k);
        a_in   = a;
        d_in   = d;
        k_in   = k;
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    // Ticks after the accepting edge until done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 12) begin
            tick();
            lat++;
        end
    endtask

    task automatic wait_digit(input int idx);
        logic [5:0] pat;
        bit ok;
        pat = ~(6'b000001 << idx);
        ok  = 1'b0;
        for (int t = 0; t < 8 * DIV; t++) begin
            if (digit_enable == pat) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("wait_digit_reached", ok, 1'b1);
    endtask

    initial begin
        int lat;
        int ndone;
        int len;
        logic [5:0] pat;

        vecs[0] = '{a: 4'd13, d: 4'd7,  k: 4'd15, digits: 24'h150713, blanks: 6'b001000};
        vecs[1] = '{a: 4'd10, d: 4'd0,  k: 4'd9,  digits: 24'h090010, blanks: 6'b101000};
        vecs[2] = '{a: 4'd0,  d: 4'd15, k: 4'd10, digits: 24'h101500, blanks: 6'b000010};
        vecs[3] = '{a: 4'd9,  d: 4'd11, k: 4'd4,  digits: 24'h041109, blanks: 6'b100010};

        update = 1'b0;
        a_in   = 4'd0;
        d_in   = 4'd0;
        k_in   = 4'd0;
        #3;
        do_reset();

        // Run mid-scan, then reset again.
        for (int i = 0; i < 11; i++) tick();
        #2;
        do_reset();

        // Scan order and dwell: digits 1..5 then 0, each exactly DIV cycles.
        wait_digit(1);
        for (int j = 1; j <= 6; j++) begin
            pat = ~(6'b000001 << (j % 6));
            check("scan_order", digit_enable, pat);
            len = 0;
            while (digit_enable == pat && len < 4 * DIV) begin
                tick();
                len++;
            end
            check("scan_dwell", len, DIV);
        end

        // Vector table: latency, then every digit value and blank.
        for (int v = 0; v < 4; v++) begin
            request(vecs[v].a, vecs[v].d, vecs[v].k);
            wait_done(lat);
            check("done_latency", lat, 3);
            tick();
            tick();
            for (int i = 0; i < 6; i++) begin
                wait_digit(i);
                check("vec_value", digit_value, vecs[v].digits[4*i +: 4]);
                check("vec_blank", digit_blank, vecs[v].blanks[i]);
            end
        end

        // Second update two cycles into a conversion is dropped.
        request(4'd5, 4'd3, 4'd4);
        tick();
        request(4'd14, 4'd14, 4'd14);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) ndone++;
        end
        check("single_done", ndone, 1);
        wait_digit(0);
        check("first_values_kept", digit_value, 4'd5);

        // Update accepted in the idle cycle right after commit.
        request(4'd1, 4'd2, 4'd3);
        wait_done(lat);
        a_in   = 4'd12;
        update = 1'b0;
        tick();
        check("idle_after_commit", busy, 1'b0);
        request(4'd12, 4'd2, 4'd3);
        check("accepted_after_commit", busy, 1'b1);
        wait_done(lat);
        check("done_latency_b2b", lat, 3);

        // Reset during a conversion: no done, digits back to zero, next update works.
        request(4'd7, 4'd8, 4'd9);
        tick();
        #2;
        do_reset();
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) ndone++;
        end
        check("no_done_after_reset", ndone, 0);
        for (int i = 0; i < 6; i++) begin
            wait_digit(i);
            check("zero_after_reset", digit_value, 4'd0);
        end
        request(4'd11, 4'd2, 4'd3);
        wait_done(lat);
        check("done_after_reset", lat, 3);

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            a_in   = 4'($urandom_range(0, 15));
            d_in   = 4'($urandom_range(0, 15));
            k_in   = 4'($urandom_range(0, 15));
            update = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 149) == 0) begin
                #2;
                do_reset();
            end
            tick();
        end
        update = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
